// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Central hazard controller for the 5-stage RV32I pipeline. Sequences
// load-use bubbles, branch/jump redirect flushes and multi-cycle LSU waits
// with a three-state FSM, and produces the EX-stage operand forwarding
// selects.
//
// Ports:
//   i_clk, i_rst                     clock, asynchronous active-low reset
//   i_rs1/rs2_addr_ID, i_rs1/rs2_used_ID   ID-stage source operands
//   i_rs1/rs2_addr_EX                EX-stage source operands (forwarding)
//   i_rd_addr_EX, i_rd_wren_EX, i_wb_sel_EX   EX-stage destination / load tag
//   i_rd_addr_MEM/WB, i_rd_wren_MEM/WB        MEM/WB destinations
//   i_redirect_EX                    EX resolved mispredict / taken jump
//   i_lsu_req_MEM, i_lsu_ack_MEM     LSU handshake in MEM
//   o_stall_IF/ID/EX/MEM             hold PC / stage register
//   o_flush_ID/EX/WB                 load bubble into stage register
//   o_fwd_a_sel, o_fwd_b_sel         00 regfile, 01 MEM result, 10 WB data
//   o_lsu_timeout                    sticky LSU timeout error
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
   parameter logic [1:0]  LOAD_SEL        = 2'b01,
   parameter int unsigned LOAD_USE_CYCLES = 32'd1,
   parameter int unsigned LSU_TIMEOUT     = 32'd255
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic [4:0] i_rs1_addr_ID,
   input  logic [4:0] i_rs2_addr_ID,
   input  logic       i_rs1_used_ID,
   input  logic       i_rs2_used_ID,
   input  logic [4:0] i_rs1_addr_EX,
   input  logic [4:0] i_rs2_addr_EX,
   input  logic [4:0] i_rd_addr_EX,
   input  logic       i_rd_wren_EX,
   input  logic [1:0] i_wb_sel_EX,
   input  logic [4:0] i_rd_addr_MEM,
   input  logic [4:0] i_rd_addr_WB,
   input  logic       i_rd_wren_MEM,
   input  logic       i_rd_wren_WB,
   input  logic       i_redirect_EX,
   input  logic       i_lsu_req_MEM,
   input  logic       i_lsu_ack_MEM,
   output logic       o_stall_IF,
   output logic       o_stall_ID,
   output logic       o_stall_EX,
   output logic       o_stall_MEM,
   output logic       o_flush_ID,
   output logic       o_flush_EX,
   output logic       o_flush_WB,
   output logic [1:0] o_fwd_a_sel,
   output logic [1:0] o_fwd_b_sel,
   output logic       o_lsu_timeout
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_LD_STALL = 2'b01,
      ST_MEM_WAIT = 2'b10
   } state_t;

   // The first bubble is issued from RUN, so the counter only holds the rest.
   localparam logic [2:0] BUBBLE_RELOAD = 3'(LOAD_USE_CYCLES - 32'd1);
   localparam logic [7:0] WAIT_LIMIT    = 8'(LSU_TIMEOUT);

   state_t     state_r;
   state_t     state_nxt_s;
   logic [2:0] bubble_cnt_r;
   logic [2:0] bubble_cnt_nxt_s;
   logic [7:0] wait_cnt_r;
   logic [7:0] wait_cnt_nxt_s;
   logic       timeout_r;
   logic       timeout_nxt_s;

   logic       mem_wait_s;
   logic       rs1_hit_s;
   logic       rs2_hit_s;
   logic       load_use_s;

   logic       stall_if_s;
   logic       stall_id_s;
   logic       stall_ex_s;
   logic       stall_mem_s;
   logic       flush_id_s;
   logic       flush_ex_s;
   logic       flush_wb_s;

   // Forwarding select for one EX operand; MEM result is newer than WB data.
   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_mem,
      input logic       wren_mem,
      input logic [4:0] rd_wb,
      input logic       wren_wb
   );
      logic [1:0] sel;
      if (wren_mem && (rd_mem != 5'd0) && (rd_mem == rs)) begin
         sel = 2'b01;
      end else if (wren_wb && (rd_wb != 5'd0) && (rd_wb == rs)) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   assign mem_wait_s = i_lsu_req_MEM & ~i_lsu_ack_MEM;
   assign rs1_hit_s  = i_rs1_used_ID & (i_rs1_addr_ID == i_rd_addr_EX);
   assign rs2_hit_s  = i_rs2_used_ID & (i_rs2_addr_ID == i_rd_addr_EX);
   assign load_use_s = (i_wb_sel_EX == LOAD_SEL) & i_rd_wren_EX &
                       (i_rd_addr_EX != 5'd0) & (rs1_hit_s | rs2_hit_s);

   // Next-state and Mealy stall/flush decode; priority mem_wait > redirect > load-use.
   always_comb begin
      state_nxt_s      = state_r;
      bubble_cnt_nxt_s = bubble_cnt_r;
      stall_if_s       = 1'b0;
      stall_id_s       = 1'b0;
      stall_ex_s       = 1'b0;
      stall_mem_s      = 1'b0;
      flush_id_s       = 1'b0;
      flush_ex_s       = 1'b0;
      flush_wb_s       = 1'b0;
      case (state_r)
         // The ack cycle of MEM_WAIT behaves exactly like RUN so that a
         // redirect or load-use seen alongside the ack is acted on at once.
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_wait_s) begin
               stall_if_s  = 1'b1;
               stall_id_s  = 1'b1;
               stall_ex_s  = 1'b1;
               stall_mem_s = 1'b1;
               flush_wb_s  = 1'b1;
               state_nxt_s = ST_MEM_WAIT;
            end else if (i_redirect_EX) begin
               flush_id_s       = 1'b1;
               flush_ex_s       = 1'b1;
               state_nxt_s      = ST_RUN;
               bubble_cnt_nxt_s = 3'd0;
            end else if (load_use_s) begin
               stall_if_s = 1'b1;
               stall_id_s = 1'b1;
               flush_ex_s = 1'b1;
               if (LOAD_USE_CYCLES > 32'd1) begin
                  bubble_cnt_nxt_s = BUBBLE_RELOAD;
                  state_nxt_s      = ST_LD_STALL;
               end else begin
                  bubble_cnt_nxt_s = 3'd0;
                  state_nxt_s      = ST_RUN;
               end
            end else begin
               state_nxt_s = ST_RUN;
            end
         end
         ST_LD_STALL: begin
            if (mem_wait_s) begin
               // Bubble count freezes while the LSU holds the pipe.
               stall_if_s  = 1'b1;
               stall_id_s  = 1'b1;
               stall_ex_s  = 1'b1;
               stall_mem_s = 1'b1;
               flush_wb_s  = 1'b1;
            end else if (i_redirect_EX) begin
               flush_id_s       = 1'b1;
               flush_ex_s       = 1'b1;
               state_nxt_s      = ST_RUN;
               bubble_cnt_nxt_s = 3'd0;
            end else begin
               stall_if_s = 1'b1;
               stall_id_s = 1'b1;
               flush_ex_s = 1'b1;
               if (bubble_cnt_r <= 3'd1) begin
                  bubble_cnt_nxt_s = 3'd0;
                  state_nxt_s      = ST_RUN;
               end else begin
                  bubble_cnt_nxt_s = bubble_cnt_r - 3'd1;
               end
            end
         end
         default: begin
            state_nxt_s      = ST_RUN;
            bubble_cnt_nxt_s = 3'd0;
         end
      endcase
   end

   // Wait counter counts consecutive LSU wait cycles, saturating at the limit.
   always_comb begin
      if (mem_wait_s) begin
         if (wait_cnt_r >= WAIT_LIMIT) begin
            wait_cnt_nxt_s = WAIT_LIMIT;
         end else begin
            wait_cnt_nxt_s = wait_cnt_r + 8'd1;
         end
      end else begin
         wait_cnt_nxt_s = 8'd0;
      end
      timeout_nxt_s = timeout_r | (mem_wait_s & (wait_cnt_nxt_s == WAIT_LIMIT));
   end

   // FSM state, counters and sticky timeout flag.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_r      <= ST_RUN;
         bubble_cnt_r <= 3'd0;
         wait_cnt_r   <= 8'd0;
         timeout_r    <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         bubble_cnt_r <= bubble_cnt_nxt_s;
         wait_cnt_r   <= wait_cnt_nxt_s;
         timeout_r    <= timeout_nxt_s;
      end
   end

   // While reset is held every stage is flushed and nothing is stalled.
   assign o_stall_IF    = stall_if_s  & i_rst;
   assign o_stall_ID    = stall_id_s  & i_rst;
   assign o_stall_EX    = stall_ex_s  & i_rst;
   assign o_stall_MEM   = stall_mem_s & i_rst;
   assign o_flush_ID    = flush_id_s  | ~i_rst;
   assign o_flush_EX    = flush_ex_s  | ~i_rst;
   assign o_flush_WB    = flush_wb_s  | ~i_rst;
   assign o_lsu_timeout = timeout_r;

   assign o_fwd_a_sel = fwd_sel(i_rs1_addr_EX, i_rd_addr_MEM, i_rd_wren_MEM,
                                i_rd_addr_WB, i_rd_wren_WB);
   assign o_fwd_b_sel = fwd_sel(i_rs2_addr_EX, i_rd_addr_MEM, i_rd_wren_MEM,
                                i_rd_addr_WB, i_rd_wren_WB);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Two controller instances share one stimulus: instance 0 uses
// LOAD_USE_CYCLES=1 / LSU_TIMEOUT=255, instance 1 uses 3 / 8. A behavioural
// model tracks, per instance, the bubbles still owed, the run length of
// consecutive LSU waits and the sticky timeout.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

   localparam int unsigned NB  [2] = '{32'd1, 32'd3};
   localparam int unsigned LIM [2] = '{32'd255, 32'd8};

   // Observation vector: {stall IF,ID,EX,MEM, flush ID,EX,WB}
   localparam logic [6:0] C_NONE   = 7'b0000000;
   localparam logic [6:0] C_RST    = 7'b0000111;
   localparam logic [6:0] C_BUBBLE = 7'b1100010;
   localparam logic [6:0] C_REDIR  = 7'b0000110;
   localparam logic [6:0] C_WAIT   = 7'b1111001;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
   logic       rs1_used, rs2_used, wren_ex, wren_mem, wren_wb;
   logic       redirect, req, ack;
   logic [1:0] wb_sel;

   logic [1:0][6:0] ctl;
   logic [1:0][1:0] fa;
   logic [1:0][1:0] fb;
   logic [1:0]      tmo;

   int checks = 0;
   int errors = 0;

   int unsigned m_pend [2] = '{32'd0, 32'd0};
   int unsigned m_wrun [2] = '{32'd0, 32'd0};
   logic        m_tmo  [2] = '{1'b0, 1'b0};

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb;
      pipeline_hazard_ctrl #(
         .LOAD_SEL       (2'b01),
         .LOAD_USE_CYCLES((g == 0) ? 32'd1 : 32'd3),
         .LSU_TIMEOUT    ((g == 0) ? 32'd255 : 32'd8)
      ) dut (
         .i_clk        (clk),
         .i_rst        (rst_n),
         .i_rs1_addr_ID(rs1_id),
         .i_rs2_addr_ID(rs2_id),
         .i_rs1_used_ID(rs1_used),
         .i_rs2_used_ID(rs2_used),
         .i_rs1_addr_EX(rs1_ex),
         .i_rs2_addr_EX(rs2_ex),
         .i_rd_addr_EX (rd_ex),
         .i_rd_wren_EX (wren_ex),
         .i_wb_sel_EX  (wb_sel),
         .i_rd_addr_MEM(rd_mem),
         .i_rd_addr_WB (rd_wb),
         .i_rd_wren_MEM(wren_mem),
         .i_rd_wren_WB (wren_wb),
         .i_redirect_EX(redirect),
         .i_lsu_req_MEM(req),
         .i_lsu_ack_MEM(ack),
         .o_stall_IF   (s_if),
         .o_stall_ID   (s_id),
         .o_stall_EX   (s_ex),
         .o_stall_MEM  (s_mem),
         .o_flush_ID   (f_id),
         .o_flush_EX   (f_ex),
         .o_flush_WB   (f_wb),
         .o_fwd_a_sel  (fa[g]),
         .o_fwd_b_sel  (fb[g]),
         .o_lsu_timeout(tmo[g])
      );
      assign ctl[g] = {s_if, s_id, s_ex, s_mem, f_id, f_ex, f_wb};
   end

   task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
      end
   endtask

   function automatic logic load_use();
      return (wb_sel == 2'b01) && wren_ex && (rd_ex != 5'd0) &&
             ((rs1_used && rs1_id == rd_ex) || (rs2_used && rs2_id == rd_ex));
   endfunction

   function automatic logic [6:0] exp_ctl(input int unsigned pend);
      if (!rst_n)            return C_RST;
      if (req && !ack)       return C_WAIT;
      if (redirect)          return C_REDIR;
      if (pend > 0 || load_use()) return C_BUBBLE;
      return C_NONE;
   endfunction

   function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
      if (wren_mem && rd_mem != 5'd0 && rd_mem == rs) return 2'b01;
      if (wren_wb && rd_wb != 5'd0 && rd_wb == rs)    return 2'b10;
      return 2'b00;
   endfunction

   // Model state: bubbles owed, consecutive wait run, sticky timeout.
   always @(posedge clk or negedge rst_n) begin
      for (int g = 0; g < 2; g++) begin
         if (!rst_n) begin
            m_pend[g] <= 0;
            m_wrun[g] <= 0;
            m_tmo[g]  <= 1'b0;
         end else if (req && !ack) begin
            m_wrun[g] <= (m_wrun[g] + 1 >= LIM[g]) ? LIM[g] : m_wrun[g] + 1;
            if (m_wrun[g] + 1 >= LIM[g]) m_tmo[g] <= 1'b1;
         end else begin
            m_wrun[g] <= 0;
            if (redirect)         m_pend[g] <= 0;
            else if (m_pend[g] > 0) m_pend[g] <= m_pend[g] - 1;
            else if (load_use())  m_pend[g] <= NB[g] - 1;
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         chk($sformatf("model_dut%0d", g), {ctl[g], fa[g], fb[g], tmo[g]},
             {exp_ctl(m_pend[g]), exp_fwd(rs1_ex), exp_fwd(rs2_ex), m_tmo[g]});
      end
   end

   task automatic idle();
      rs1_id = 5'd0; rs2_id = 5'd0; rs1_ex = 5'd0; rs2_ex = 5'd0;
      rd_ex = 5'd0; rd_mem = 5'd0; rd_wb = 5'd0;
      rs1_used = 1'b0; rs2_used = 1'b0; wren_ex = 1'b0; wren_mem = 1'b0;
      wren_wb = 1'b0; redirect = 1'b0; req = 1'b0; ack = 1'b0; wb_sel = 2'b00;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   // lw x5 in EX, add x6,x5,x7 in ID
   task automatic lw_hazard();
      wb_sel = 2'b01; wren_ex = 1'b1; rd_ex = 5'd5;
      rs1_id = 5'd5; rs1_used = 1'b1; rs2_id = 5'd7; rs2_used = 1'b1;
   endtask

   int burst = 0;

   initial begin
      idle();
      #1 rst_n = 1'b0;
      nxt(); nxt(); #1;
      chk("rst_ctl", 12'(ctl[0]), 12'(C_RST));
      chk("rst_tmo", 12'(tmo[1]), 12'd0);
      nxt(); rst_n = 1'b1; #1;
      chk("idle_ctl", 12'(ctl[0]), 12'(C_NONE));
      chk("idle_fwd", 12'({fa[0], fb[0]}), 12'd0);
      nxt();

      // Load-use: 1 bubble vs 3 bubbles
      nxt(); lw_hazard(); #1;
      chk("lu1_c1", 12'(ctl[0]), 12'(C_BUBBLE));
      chk("lu3_c1", 12'(ctl[1]), 12'(C_BUBBLE));
      nxt(); idle(); #1;
      chk("lu1_c2", 12'(ctl[0]), 12'(C_NONE));
      chk("lu3_c2", 12'(ctl[1]), 12'(C_BUBBLE));
      nxt(); #1;
      chk("lu3_c3", 12'(ctl[1]), 12'(C_BUBBLE));
      nxt(); #1;
      chk("lu3_c4", 12'(ctl[1]), 12'(C_NONE));
      nxt(); lw_hazard(); rd_ex = 5'd0; rs1_id = 5'd0; #1;
      chk("lu_x0", 12'({ctl[0], ctl[1]}), 12'd0);
      nxt(); lw_hazard(); rs1_used = 1'b0; #1;
      chk("lu_unused", 12'({ctl[0], ctl[1]}), 12'd0);

      // Redirect wins over load-use; redirect aborts bubbles
      nxt(); lw_hazard(); redirect = 1'b1; #1;
      chk("redir_lu0", 12'(ctl[0]), 12'(C_REDIR));
      chk("redir_lu1", 12'(ctl[1]), 12'(C_REDIR));
      nxt(); idle(); #1;
      chk("redir_after", 12'(ctl[1]), 12'(C_NONE));
      nxt(); lw_hazard(); #1;
      chk("abort_c1", 12'(ctl[1]), 12'(C_BUBBLE));
      nxt(); idle(); redirect = 1'b1; #1;
      chk("abort_c2", 12'(ctl[1]), 12'(C_REDIR));
      nxt(); idle(); #1;
      chk("abort_c3", 12'(ctl[1]), 12'(C_NONE));

      // LSU wait 4 cycles, ack in cycle 5
      for (int k = 0; k < 4; k++) begin
         nxt(); idle(); req = 1'b1; #1;
         chk($sformatf("wait_c%0d", k), 12'(ctl[0]), 12'(C_WAIT));
      end
      nxt(); req = 1'b1; ack = 1'b1; #1;
      chk("wait_ack", 12'(ctl[0]), 12'(C_NONE));
      for (int k = 0; k < 4; k++) begin
         nxt(); idle(); req = 1'b1; redirect = 1'b1; #1;
         chk($sformatf("waitr_c%0d", k), 12'(ctl[1]), 12'(C_WAIT));
      end
      nxt(); req = 1'b1; ack = 1'b1; redirect = 1'b1; #1;
      chk("waitr_ack", 12'(ctl[1]), 12'(C_REDIR));

      // Timeout at 8 consecutive wait cycles on instance 1
      for (int k = 1; k <= 10; k++) begin
         nxt(); idle(); req = 1'b1; #1;
         chk($sformatf("tmo_c%0d", k), 12'({tmo[1], tmo[0]}), (k > 8) ? 12'd2 : 12'd0);
      end
      nxt(); req = 1'b1; ack = 1'b1; #1;
      chk("tmo_ack", 12'(tmo[1]), 12'd1);
      nxt(); idle(); #1;
      chk("tmo_sticky", 12'(tmo[1]), 12'd1);

      // Asynchronous reset in the middle of a wait
      nxt(); req = 1'b1;
      nxt(); rst_n = 1'b0; #1;
      chk("arst_tmo", 12'(tmo[1]), 12'd0);
      chk("arst_ctl", 12'(ctl[1]), 12'(C_RST));
      nxt(); rst_n = 1'b1; idle(); #1;
      chk("arst_rel", 12'(ctl[1]), 12'(C_NONE));

      // Forwarding
      nxt(); rs1_ex = 5'd3; rd_mem = 5'd3; wren_mem = 1'b1; rd_wb = 5'd3; wren_wb = 1'b1; #1;
      chk("fwd_mem", 12'(fa[0]), 12'd1);
      nxt(); wren_mem = 1'b0; #1;
      chk("fwd_wb", 12'(fa[0]), 12'd2);
      nxt(); rs2_ex = 5'd0; rd_wb = 5'd0; wren_wb = 1'b1; rd_mem = 5'd0; wren_mem = 1'b1; #1;
      chk("fwd_x0", 12'(fb[0]), 12'd0);
      nxt(); idle();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         nxt();
         rst_n    = ($urandom_range(0, 249) != 0);
         rs1_id   = 5'($urandom_range(0, 3));
         rs2_id   = 5'($urandom_range(0, 3));
         rs1_ex   = 5'($urandom_range(0, 3));
         rs2_ex   = 5'($urandom_range(0, 3));
         rd_ex    = 5'($urandom_range(0, 3));
         rd_mem   = 5'($urandom_range(0, 3));
         rd_wb    = 5'($urandom_range(0, 3));
         rs1_used = 1'($urandom_range(0, 1));
         rs2_used = 1'($urandom_range(0, 1));
         wren_ex  = 1'($urandom_range(0, 1));
         wren_mem = 1'($urandom_range(0, 1));
         wren_wb  = 1'($urandom_range(0, 1));
         wb_sel   = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
         redirect = ($urandom_range(0, 5) == 0);
         if (burst == 0 && $urandom_range(0, 59) == 0) burst = int'($urandom_range(5, 12));
         if (burst > 0) begin
            burst = burst - 1;
            req = 1'b1;
            ack = 1'b0;
         end else begin
            req = 1'($urandom_range(0, 1));
            ack = ($urandom_range(0, 2) == 0);
         end
      end
      nxt(); rst_n = 1'b1; idle();
      nxt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard controller for the 5-stage RV32I pipeline. It drives the stall and flush inputs of the IF, ID, EX, MEM and WB pipeline registers and of the PC. It sequences load-use bubbles, branch/jump redirect flushes and multi-cycle LSU waits through a small FSM. It also produces the combinational EX-stage forwarding selects.

Parameters:
LOAD_SEL, 2'b01, wb_sel encoding that marks a load instruction
LOAD_USE_CYCLES, 1, bubble cycles per load-use hazard (1..7)
LSU_TIMEOUT, 255, max MEM_WAIT cycles before the error flag sets (1..255)

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-low
i_rs1_addr_ID, i_rs2_addr_ID  in  5  source regs of instruction in ID
i_rs1_used_ID, i_rs2_used_ID  in  1  instruction in ID reads rs1/rs2
i_rs1_addr_EX, i_rs2_addr_EX  in  5  source regs in EX (forwarding)
i_rd_addr_EX  in  5  dest reg in EX
i_rd_wren_EX  in  1  EX writes rd
i_wb_sel_EX  in  2  EX writeback select
i_rd_addr_MEM, i_rd_addr_WB  in  5  dest regs in MEM/WB
i_rd_wren_MEM, i_rd_wren_WB  in  1  MEM/WB write rd
i_redirect_EX  in  1  EX resolved mispredict / taken jump
i_lsu_req_MEM  in  1  MEM stage has an LSU access
i_lsu_ack_MEM  in  1  LSU access completes this cycle
o_stall_IF, o_stall_ID, o_stall_EX, o_stall_MEM  out  1  hold PC / stage register
o_flush_ID, o_flush_EX, o_flush_WB  out  1  load bubble into stage register
o_fwd_a_sel, o_fwd_b_sel  out  2  00 regfile, 01 MEM result, 10 WB data
o_lsu_timeout  out  1  sticky LSU timeout error

Behaviour:
- FSM states: RUN, LD_STALL, MEM_WAIT. Plus a 3-bit bubble counter, an 8-bit wait counter and the timeout flag. Outputs are Mealy, from state and current inputs.
- Reset (i_rst=0): state RUN, counters 0, o_lsu_timeout=0. All stalls 0, all flushes 1 while reset is held.
- mem_wait = i_lsu_req_MEM & ~i_lsu_ack_MEM.
- load_use = (i_wb_sel_EX==LOAD_SEL) & i_rd_wren_EX & (i_rd_addr_EX!=0) & ((i_rs1_used_ID & rs1_ID==rd_EX) | (i_rs2_used_ID & rs2_ID==rd_EX)).
- Priority in every state: mem_wait > redirect > load-use.
- mem_wait (any state):
  - Outputs: stall_IF/ID/EX/MEM=1 and flush_WB=1. No other flush.
  - From RUN, the next state is MEM_WAIT.
  - In LD_STALL the bubble counter freezes and the state stays LD_STALL.
- MEM_WAIT:
  - Outputs while ~ack: stall_IF/ID/EX/MEM=1, flush_WB=1. The wait counter increments and saturates at LSU_TIMEOUT; reaching it sets o_lsu_timeout, which holds until reset. The stall continues regardless.
  - On ack: no stalls, wait counter cleared, next state RUN. A redirect or load-use present in the ack cycle is acted on in that same cycle.
- Redirect (RUN or LD_STALL, no mem_wait): flush_ID=1, flush_EX=1, stall_IF=0. The PC takes the redirect target. Next state RUN; any pending bubble count is aborted. A load-use hazard in the same cycle is ignored because its ID instruction is wrong-path.
- Load-use (RUN, no mem_wait, no redirect):
  - Outputs: stall_IF=1, stall_ID=1, flush_EX=1.
  - If LOAD_USE_CYCLES>1: load the bubble counter with LOAD_USE_CYCLES-1 and go to LD_STALL.
- LD_STALL: outputs as for load-use, without rechecking the hazard. The counter decrements each non-frozen cycle; the cycle in which it reads 1 is the last, and the next state is RUN. Total bubbles equal LOAD_USE_CYCLES exactly.
- Forwarding (combinational, independent of FSM), for operand A:
  - 01 if i_rd_wren_MEM & rd_MEM!=0 & rd_MEM==rs1_EX;
  - else 10 if i_rd_wren_WB & rd_WB!=0 & rd_WB==rs1_EX;
  - else 00.
  - Operand B is the same with rs2_EX. MEM takes priority over WB.
- Stall and flush asserted together on the same register: flush wins at the register. The controller itself never drives both for one stage.

Test Plan:
- Reset then release, no hazards: all stalls/flushes 0 and fwd_sel=00. Assert i_rst=0 mid-MEM_WAIT: state returns to RUN, flushes go to 1 and o_lsu_timeout clears asynchronously.
- Load-use: EX lw x5 (wb_sel=01, wren=1), ID add x6,x5,x7 (rs1_used=1). With LOAD_USE_CYCLES=1: stall_IF/ID=1 and flush_EX=1 for exactly 1 cycle. With LOAD_USE_CYCLES=3: exactly 3 cycles. rd=x0, or rs1_used=0: no stall.
- Redirect and load-use in the same cycle: only flush_ID=flush_EX=1, no stall. Redirect in the 2nd LD_STALL cycle (LOAD_USE_CYCLES=3): bubbles abort and the state returns to RUN.
- LSU wait: req=1 with ack low for 4 cycles: stall_IF..MEM=1 and flush_WB=1 for 4 cycles; ack in cycle 5 releases. A redirect held through the wait produces flushes only in the ack cycle.
- Timeout: LSU_TIMEOUT=8, ack withheld 10 cycles: o_lsu_timeout rises after 8 wait cycles and stays 1 after ack.
- Forwarding: rs1_EX=x3 with MEM rd=x3 and WB rd=x3 gives fwd_a=01. MEM wren=0 gives 10. rs2_EX=x0 matching WB rd=x0 gives fwd_b=00.
